// File: rtl/timer_pkg.sv
// Shared types and constants for the irrigation timer upper-digit stage.
package timer_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam bcd_t BCD_ZERO      = 4'd0;
  localparam bcd_t BCD_NINE      = 4'd9;
  localparam bcd_t SEC_T_MAX_DEF = 4'd5;

  // Saturate a BCD value so a bad preset can never show a digit above its max.
  function automatic bcd_t bcd_clamp(input bcd_t value, input bcd_t max_val);
    bcd_t result;
    if (value > max_val) begin
      result = max_val;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/timer_upper_digits_if.sv
// Preset/load, units-stage and display bundle of the upper-digit timer stage.
interface timer_upper_digits_if;
  import timer_pkg::*;

  logic load;
  bcd_t preset_sec_t;
  bcd_t preset_min_u;
  bcd_t preset_min_t;
  bcd_t units_bcd;
  logic borrow_in;

  bcd_t sec_t;
  bcd_t min_u;
  bcd_t min_t;
  logic reach_zero;
  logic units_clear;
  logic running;

  modport master (
    output load, preset_sec_t, preset_min_u, preset_min_t, units_bcd, borrow_in,
    input  sec_t, min_u, min_t, reach_zero, units_clear, running
  );

  modport slave (
    input  load, preset_sec_t, preset_min_u, preset_min_t, units_bcd, borrow_in,
    output sec_t, min_u, min_t, reach_zero, units_clear, running
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: clamped load, wrap to MAX on decrement from 0.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter bcd_t MAX = BCD_NINE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  bcd_t load_val_i,
  input  logic dec_i,
  output bcd_t value_o,
  output logic borrow_o
);

  bcd_t value_q;
  bcd_t value_d;

  // Load has priority over decrement; a decrement from zero wraps to MAX.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = bcd_clamp(load_val_i, MAX);
    end else if (dec_i) begin
      if (value_q == BCD_ZERO) begin
        value_d = MAX;
      end else begin
        value_d = value_q - 4'd1;
      end
    end else begin
      value_d = value_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= BCD_ZERO;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o  = value_q;
  assign borrow_o = dec_i & (value_q == BCD_ZERO);

endmodule

// File: rtl/timer_upper_digits.sv
// Tens-of-seconds and minutes countdown driven by borrow strobes from the
// asynchronous seconds-units stage; also drives that stage's clear and pause.
module timer_upper_digits
  import timer_pkg::*;
#(
  parameter int SEC_T_MAX    = 5,
  parameter int MIN_MAX      = 9,
  parameter int SYNC_STAGES  = 2,
  parameter int BLANK_CYCLES = 3
) (
  input logic clk,
  input logic rst_n,
  timer_upper_digits_if.slave bus_if
);

  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);

  bcd_t                 units_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] borrow_sync_q;
  logic                 borrow_prev_q;
  logic                 event_q;
  logic [BLANK_W-1:0]   blank_q;
  state_e               state_q;
  logic                 reach_zero_q;
  logic                 units_clear_q;
  logic                 running_q;

  bcd_t sec_t_s;
  bcd_t min_u_s;
  bcd_t min_t_s;
  logic sec_t_borrow_s;
  logic min_u_borrow_s;
  logic unused_min_t_borrow_s;
  logic borrow_synced_s;
  logic borrow_edge_s;
  logic digits_zero_s;
  logic any_preset_s;
  logic dec_en_s;
  logic expire_s;

  // Synchronizer chains for the ripple-clocked units digit and its borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        units_sync_q[i] <= BCD_ZERO;
      end
      borrow_sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      units_sync_q[0] <= bus_if.units_bcd;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        units_sync_q[i] <= units_sync_q[i-1];
      end
      borrow_sync_q <= {borrow_sync_q[SYNC_STAGES-2:0], bus_if.borrow_in};
    end
  end

  assign borrow_synced_s = borrow_sync_q[SYNC_STAGES-1];
  assign borrow_edge_s   = borrow_synced_s & ~borrow_prev_q;

  // Registered borrow event and post-load blanking window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_prev_q <= 1'b0;
      event_q       <= 1'b0;
      blank_q       <= {BLANK_W{1'b0}};
    end else begin
      borrow_prev_q <= borrow_synced_s;
      event_q       <= borrow_edge_s & ~bus_if.load;
      if (bus_if.load) begin
        blank_q <= BLANK_W'(BLANK_CYCLES);
      end else if (blank_q != {BLANK_W{1'b0}}) begin
        blank_q <= blank_q - BLANK_W'(1);
      end else begin
        blank_q <= blank_q;
      end
    end
  end

  // Decrement and expiry qualification; the all-zero guard prevents underflow.
  always_comb begin
    digits_zero_s = (sec_t_s == BCD_ZERO) && (min_u_s == BCD_ZERO) && (min_t_s == BCD_ZERO);
    any_preset_s  = (bus_if.preset_sec_t != BCD_ZERO) || (bus_if.preset_min_u != BCD_ZERO) ||
                    (bus_if.preset_min_t != BCD_ZERO);
    dec_en_s      = (state_q == ST_RUN) && event_q && (blank_q == {BLANK_W{1'b0}}) &&
                    !bus_if.load && !digits_zero_s;
    expire_s      = (state_q == ST_RUN) && digits_zero_s &&
                    (units_sync_q[SYNC_STAGES-1] == BCD_ZERO) && (blank_q == {BLANK_W{1'b0}});
  end

  // Control FSM with registered reach_zero, units_clear and running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      reach_zero_q  <= 1'b0;
      units_clear_q <= 1'b1;
      running_q     <= 1'b0;
    end else if (bus_if.load) begin
      state_q       <= any_preset_s ? ST_RUN : ST_DONE;
      reach_zero_q  <= 1'b0;
      units_clear_q <= 1'b1;
      running_q     <= any_preset_s;
    end else begin
      units_clear_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_q      <= ST_IDLE;
          reach_zero_q <= 1'b0;
          running_q    <= 1'b0;
        end
        ST_RUN: begin
          if (expire_s) begin
            state_q      <= ST_DONE;
            reach_zero_q <= 1'b1;
            running_q    <= 1'b0;
          end else begin
            state_q      <= ST_RUN;
            reach_zero_q <= 1'b0;
            running_q    <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q      <= ST_DONE;
          reach_zero_q <= 1'b1;
          running_q    <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          reach_zero_q <= 1'b0;
          running_q    <= 1'b0;
        end
      endcase
    end
  end

  bcd_down_digit #(.MAX(BCD_W'(SEC_T_MAX))) u_sec_t (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (bus_if.load),
    .load_val_i (bus_if.preset_sec_t),
    .dec_i      (dec_en_s),
    .value_o    (sec_t_s),
    .borrow_o   (sec_t_borrow_s)
  );

  bcd_down_digit #(.MAX(BCD_W'(MIN_MAX))) u_min_u (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (bus_if.load),
    .load_val_i (bus_if.preset_min_u),
    .dec_i      (sec_t_borrow_s),
    .value_o    (min_u_s),
    .borrow_o   (min_u_borrow_s)
  );

  bcd_down_digit #(.MAX(BCD_W'(MIN_MAX))) u_min_t (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (bus_if.load),
    .load_val_i (bus_if.preset_min_t),
    .dec_i      (min_u_borrow_s),
    .value_o    (min_t_s),
    .borrow_o   (unused_min_t_borrow_s)
  );

  assign bus_if.sec_t       = sec_t_s;
  assign bus_if.min_u       = min_u_s;
  assign bus_if.min_t       = min_t_s;
  assign bus_if.reach_zero  = reach_zero_q;
  assign bus_if.units_clear = units_clear_q;
  assign bus_if.running     = running_q;

endmodule

// File: tb/tb_timer_upper_digits.sv
// Self-checking bench for timer_upper_digits against a remaining-time model.
module tb_timer_upper_digits;

  localparam int BLANK_CYCLES = 3;
  localparam int SYNC_STAGES  = 2;

  logic clk;
  logic rst_n;

  timer_upper_digits_if bus_if ();

  timer_upper_digits #(
    .SEC_T_MAX    (5),
    .MIN_MAX      (9),
    .SYNC_STAGES  (SYNC_STAGES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: remaining time in tens of seconds; state 0 idle, 1 run, 2 done.
  int model_t     = 0;
  int model_state = 0;

  function automatic int clamp_i(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [11:0] model_digits(input int t);
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    mt = 4'(t / 60);
    mu = 4'((t / 6) % 10);
    st = 4'(t % 6);
    return {mt, mu, st};
  endfunction

  function automatic logic [11:0] dut_digits();
    return {bus_if.min_t, bus_if.min_u, bus_if.sec_t};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [3:0] st, input logic [3:0] mu, input logic [3:0] mt,
                         input bit settle);
    bus_if.load         = 1'b1;
    bus_if.preset_sec_t = st;
    bus_if.preset_min_u = mu;
    bus_if.preset_min_t = mt;
    bus_if.units_bcd    = 4'd0;
    bus_if.borrow_in    = 1'b0;
    tick();
    bus_if.load = 1'b0;
    model_t     = clamp_i(int'(mt), 9) * 60 + clamp_i(int'(mu), 9) * 6 + clamp_i(int'(st), 5);
    model_state = (model_t == 0) ? 2 : 1;
    if (settle) repeat (BLANK_CYCLES + 2) tick();
  endtask

  // Units stage wraps 0->9 (borrow high while 9), then counts on to 8.
  task automatic borrow_pulse();
    bus_if.units_bcd = 4'd9;
    bus_if.borrow_in = 1'b1;
    repeat (3) tick();
    bus_if.units_bcd = 4'd8;
    bus_if.borrow_in = 1'b0;
    repeat (3) tick();
    if (model_state == 1 && model_t > 0) model_t = model_t - 1;
  endtask

  task automatic test_reset();
    rst_n               = 1'b0;
    bus_if.load         = 1'b0;
    bus_if.preset_sec_t = 4'd0;
    bus_if.preset_min_u = 4'd0;
    bus_if.preset_min_t = 4'd0;
    bus_if.units_bcd    = 4'd0;
    bus_if.borrow_in    = 1'b0;
    #12;
    n_total++;
    if (bus_if.units_clear !== 1'b1) $display("FAIL reset_units_clear got %b want 1", bus_if.units_clear);
    else n_pass++;
    n_total++;
    if (dut_digits() !== 12'h000) $display("FAIL reset_digits got %h want 000", dut_digits());
    else n_pass++;
    n_total++;
    if (bus_if.running !== 1'b0) $display("FAIL reset_running got %b want 0", bus_if.running);
    else n_pass++;
    n_total++;
    if (bus_if.reach_zero !== 1'b0) $display("FAIL reset_reach_zero got %b want 0", bus_if.reach_zero);
    else n_pass++;
    #10;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (bus_if.units_clear !== 1'b1) $display("FAIL release_units_clear got %b want 1", bus_if.units_clear);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bus_if.units_clear !== 1'b0) $display("FAIL first_clock_units_clear got %b want 0", bus_if.units_clear);
    else n_pass++;
    @(negedge clk);
    model_t     = 0;
    model_state = 0;
  endtask

  task automatic test_cascade();
    logic [3:0] st_v [3] = '{4'd3, 4'd0, 4'd0};
    logic [3:0] mu_v [3] = '{4'd1, 4'd1, 4'd0};
    logic [3:0] mt_v [3] = '{4'd0, 4'd0, 4'd1};
    for (int i = 0; i < 3; i++) begin
      do_load(st_v[i], mu_v[i], mt_v[i], 1'b1);
      borrow_pulse();
      n_total++;
      if (dut_digits() !== model_digits(model_t))
        $display("FAIL cascade_%0d digits got %h want %h", i, dut_digits(), model_digits(model_t));
      else n_pass++;
      n_total++;
      if (bus_if.running !== 1'b1) $display("FAIL cascade_%0d running got %b want 1", i, bus_if.running);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int npulse;
      do_load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      npulse = $urandom_range(0, 7);
      for (int p = 0; p < npulse; p++) borrow_pulse();
      n_total++;
      if (dut_digits() !== model_digits(model_t))
        $display("FAIL random_%0d digits got %h want %h", it, dut_digits(), model_digits(model_t));
      else n_pass++;
      n_total++;
      if (bus_if.running !== (model_state == 1))
        $display("FAIL random_%0d running got %b want %b", it, bus_if.running, model_state == 1);
      else n_pass++;
      n_total++;
      if (bus_if.reach_zero !== (model_state == 2))
        $display("FAIL random_%0d reach_zero got %b want %b", it, bus_if.reach_zero, model_state == 2);
      else n_pass++;
    end
  endtask

  task automatic test_expiry();
    int waited;
    do_load(4'd1, 4'd0, 4'd0, 1'b1);
    bus_if.units_bcd = 4'd9;
    bus_if.borrow_in = 1'b1;
    repeat (3) tick();
    bus_if.borrow_in = 1'b0;
    for (int u = 8; u >= 1; u--) begin
      bus_if.units_bcd = 4'(u);
      tick();
    end
    n_total++;
    if (dut_digits() !== 12'h000) $display("FAIL expiry_digits got %h want 000", dut_digits());
    else n_pass++;
    n_total++;
    if (bus_if.reach_zero !== 1'b0) $display("FAIL expiry_early got %b want 0", bus_if.reach_zero);
    else n_pass++;
    bus_if.units_bcd = 4'd0;
    waited = 0;
    while (bus_if.reach_zero !== 1'b1 && waited < SYNC_STAGES + 2) begin
      tick();
      waited++;
    end
    n_total++;
    if (bus_if.reach_zero !== 1'b1)
      $display("FAIL expiry_reach_zero got %b want 1 within %0d cycles", bus_if.reach_zero, SYNC_STAGES + 2);
    else n_pass++;
    model_t     = 0;
    model_state = 2;
    borrow_pulse();
    bus_if.units_bcd = 4'd0;
    n_total++;
    if (dut_digits() !== 12'h000) $display("FAIL done_borrow_digits got %h want 000", dut_digits());
    else n_pass++;
    n_total++;
    if (bus_if.reach_zero !== 1'b1 || bus_if.running !== 1'b0)
      $display("FAIL done_hold got rz=%b run=%b want rz=1 run=0", bus_if.reach_zero, bus_if.running);
    else n_pass++;
  endtask

  task automatic test_clamp_and_zero_load();
    do_load(4'd7, 4'hC, 4'd0, 1'b1);
    n_total++;
    if (dut_digits() !== 12'h095) $display("FAIL clamp_digits got %h want 095", dut_digits());
    else n_pass++;
    do_load(4'd0, 4'd0, 4'd0, 1'b0);
    n_total++;
    if (bus_if.units_clear !== 1'b1 || bus_if.reach_zero !== 1'b0)
      $display("FAIL zero_load_edge got uc=%b rz=%b want uc=1 rz=0", bus_if.units_clear, bus_if.reach_zero);
    else n_pass++;
    tick();
    n_total++;
    if (bus_if.reach_zero !== 1'b1 || bus_if.units_clear !== 1'b0)
      $display("FAIL zero_load_next got rz=%b uc=%b want rz=1 uc=0", bus_if.reach_zero, bus_if.units_clear);
    else n_pass++;
  endtask

  task automatic test_load_collision();
    do_load(4'd3, 4'd5, 4'd0, 1'b1);
    bus_if.units_bcd = 4'd9;
    bus_if.borrow_in = 1'b1;
    repeat (3) tick();
    do_load(4'd0, 4'd2, 4'd0, 1'b1);
    n_total++;
    if (dut_digits() !== model_digits(model_t))
      $display("FAIL collision_digits got %h want %h", dut_digits(), model_digits(model_t));
    else n_pass++;
    // Borrow rising together with load lands inside the blanking window.
    bus_if.load         = 1'b1;
    bus_if.preset_sec_t = 4'd0;
    bus_if.preset_min_u = 4'd3;
    bus_if.preset_min_t = 4'd0;
    bus_if.units_bcd    = 4'd9;
    bus_if.borrow_in    = 1'b1;
    tick();
    bus_if.load = 1'b0;
    model_t     = 18;
    model_state = 1;
    repeat (6) tick();
    bus_if.borrow_in = 1'b0;
    bus_if.units_bcd = 4'd8;
    repeat (3) tick();
    n_total++;
    if (dut_digits() !== model_digits(model_t))
      $display("FAIL blank_digits got %h want %h", dut_digits(), model_digits(model_t));
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    do_load(4'd3, 4'd5, 4'd0, 1'b1);
    borrow_pulse();
    n_total++;
    if (dut_digits() !== model_digits(model_t))
      $display("FAIL prereset_digits got %h want %h", dut_digits(), model_digits(model_t));
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    model_t     = 0;
    model_state = 0;
    n_total++;
    if (dut_digits() !== 12'h000 || bus_if.running !== 1'b0 || bus_if.units_clear !== 1'b1)
      $display("FAIL midrun_reset got d=%h run=%b uc=%b want d=000 run=0 uc=1",
               dut_digits(), bus_if.running, bus_if.units_clear);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (BLANK_CYCLES + 2) tick();
    borrow_pulse();
    n_total++;
    if (dut_digits() !== 12'h000 || bus_if.running !== 1'b0 || bus_if.reach_zero !== 1'b0)
      $display("FAIL idle_borrow got d=%h run=%b rz=%b want d=000 run=0 rz=0",
               dut_digits(), bus_if.running, bus_if.reach_zero);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cascade();
    test_clamp_and_zero_load();
    test_expiry();
    test_load_collision();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
